// File: rtl/reaper_pkg.sv
// Shared encodings for the Reaper phase sequencer: phase states and IO direction.
package reaper_pkg;
   typedef enum logic [2:0] {
      PH_IDLE    = 3'd0,
      PH_FETCH   = 3'd1,
      PH_DECODE  = 3'd2,
      PH_EXEC    = 3'd3,
      PH_MEM     = 3'd4,
      PH_WB      = 3'd5,
      PH_IO_WAIT = 3'd6,
      PH_HALT    = 3'd7
   } phase_e;

   localparam logic IO_SEL_IN  = 1'b0;
   localparam logic IO_SEL_OUT = 1'b1;
endpackage

// File: rtl/phase_prescaler.sv
// Phase tick generator: counts 0..PRESCALE-1 and flags the last count; clr restarts the count.
module phase_prescaler #(
   parameter int PRESCALE = 16
) (
   input  logic gclk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + PW'(1);
      if (clr || cnt_q == LAST) cnt_d = '0;
   end

   always_ff @(posedge gclk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);
endmodule

// File: rtl/proc_phase_sequencer.sv
// Multi-phase instruction sequencer: walks FETCH..WB, stalls on IO input, parks on Halt,
// and emits one-cycle commit strobes on the tick that leaves each phase.
module proc_phase_sequencer
   import reaper_pkg::*;
#(
   parameter int PRESCALE = 16,
   parameter int MEM_WAIT = 2,
   parameter int CNT_W    = 32
) (
   input  logic             Fast_Clock,
   input  logic             Reset,
   input  logic             Run_Mode,
   input  logic             Step_Req,
   input  logic             Halt,
   input  logic             IO_Enable,
   input  logic             IO_Selection,
   input  logic             Confirm,
   output logic             Fetch_En,
   output logic             Exec_En,
   output logic             Mem_En,
   output logic             WB_En,
   output logic             PC_En,
   output logic [2:0]       Phase,
   output logic             Waiting_IO,
   output logic             Halted,
   output logic [CNT_W-1:0] Retired
);
   localparam int MW_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
   localparam logic [MW_W-1:0] MEM_LAST = MW_W'(MEM_WAIT - 1);

   phase_e           state_q, state_d;
   logic [MW_W-1:0]  mem_cnt_q, mem_cnt_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             step_q, confirm_q;
   logic             tick, step_rise, confirm_rise, io_input, mem_last;

   assign step_rise    = Step_Req & ~step_q;
   assign confirm_rise = Confirm & ~confirm_q;
   assign io_input     = IO_Enable && (IO_Selection == IO_SEL_IN);
   assign mem_last     = tick && (mem_cnt_q == MEM_LAST);

   // Every state change restarts the phase timer so each phase gets a full PRESCALE window.
   phase_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .gclk (Fast_Clock),
      .rst  (Reset),
      .clr  (state_d != state_q),
      .tick (tick)
   );

   always_ff @(posedge Fast_Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= PH_IDLE;
         mem_cnt_q <= '0;
         retired_q <= '0;
         step_q    <= 1'b0;
         confirm_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mem_cnt_q <= mem_cnt_d;
         retired_q <= retired_d;
         step_q    <= Step_Req;
         confirm_q <= Confirm;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         PH_IDLE:    if (Run_Mode || step_rise) state_d = PH_FETCH;
         PH_FETCH:   if (tick) state_d = PH_DECODE;
         PH_DECODE:  if (tick) state_d = Halt ? PH_HALT : PH_EXEC;
         PH_EXEC:    if (tick) state_d = io_input ? PH_IO_WAIT : PH_MEM;
         PH_IO_WAIT: if (confirm_rise) state_d = PH_MEM;
         PH_MEM:     if (mem_last) state_d = PH_WB;
         PH_WB:      if (tick) state_d = Run_Mode ? PH_FETCH : PH_IDLE;
         PH_HALT:    state_d = PH_HALT;
      endcase
   end

   always_comb begin
      mem_cnt_d = '0;
      if (state_q == PH_MEM) mem_cnt_d = (tick && !mem_last) ? mem_cnt_q + MW_W'(1) : mem_cnt_q;
      retired_d = retired_q;
      if (state_q == PH_WB && tick && retired_q != '1) retired_d = retired_q + CNT_W'(1);
   end

   always_comb begin
      Fetch_En   = (state_q == PH_FETCH) && tick;
      Exec_En    = (state_q == PH_EXEC) && tick;
      Mem_En     = (state_q == PH_MEM) && mem_last;
      WB_En      = (state_q == PH_WB) && tick;
      PC_En      = (state_q == PH_WB) && tick;
      Waiting_IO = (state_q == PH_IO_WAIT);
      Halted     = (state_q == PH_HALT);
      Phase      = state_q;
      Retired    = retired_q;
   end
endmodule

// File: tb/tb_proc_phase_sequencer.sv
// Randomized bench: two sequencer configurations checked every cycle against a phase/age model.
module tb_proc_phase_sequencer;
   localparam int P_F = 1, MW_F = 2, CW_F = 4;
   localparam int P_S = 4, MW_S = 3, CW_S = 8;

   logic clk = 1'b0, rst = 1'b0;
   logic run = 1'b0, step = 1'b0, halt = 1'b0, io_en = 1'b0, io_sel = 1'b0, conf = 1'b0;
   always #5 clk = ~clk;

   logic f_fe, f_ee, f_me, f_wb, f_pc, f_wt, f_ht;
   logic s_fe, s_ee, s_me, s_wb, s_pc, s_wt, s_ht;
   logic [2:0] f_ph, s_ph;
   logic [CW_F-1:0] f_ret;
   logic [CW_S-1:0] s_ret;
   wire [9:0] f_vec = {f_ph, f_fe, f_ee, f_me, f_wb, f_pc, f_wt, f_ht};
   wire [9:0] s_vec = {s_ph, s_fe, s_ee, s_me, s_wb, s_pc, s_wt, s_ht};

   proc_phase_sequencer #(.PRESCALE(P_F), .MEM_WAIT(MW_F), .CNT_W(CW_F)) u_fast (
      .Fast_Clock(clk), .Reset(rst), .Run_Mode(run), .Step_Req(step), .Halt(halt),
      .IO_Enable(io_en), .IO_Selection(io_sel), .Confirm(conf),
      .Fetch_En(f_fe), .Exec_En(f_ee), .Mem_En(f_me), .WB_En(f_wb), .PC_En(f_pc),
      .Phase(f_ph), .Waiting_IO(f_wt), .Halted(f_ht), .Retired(f_ret));

   proc_phase_sequencer #(.PRESCALE(P_S), .MEM_WAIT(MW_S), .CNT_W(CW_S)) u_slow (
      .Fast_Clock(clk), .Reset(rst), .Run_Mode(run), .Step_Req(step), .Halt(halt),
      .IO_Enable(io_en), .IO_Selection(io_sel), .Confirm(conf),
      .Fetch_En(s_fe), .Exec_En(s_ee), .Mem_En(s_me), .WB_En(s_wb), .PC_En(s_pc),
      .Phase(s_ph), .Waiting_IO(s_wt), .Halted(s_ht), .Retired(s_ret));

   // ph: phase number, age: cycles spent in it so far, ret: instructions retired
   typedef struct { int ph; int age; int ret; } ms_t;
   ms_t mf, msl;
   bit  prev_step, prev_conf;
   int  total = 0, bad = 0;
   int  mode = 4, rst_req = 1;
   int  pc_f = 0, bad_strb = 0;
   logic m_run = 0, m_step = 0, m_halt = 0, m_io_en = 0, m_io_sel = 0, m_conf = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic ms_t nxt(input ms_t s, input int p, input int mw, input int cmax);
      ms_t n;
      bit  tk;
      n  = s;
      tk = ((s.age + 1) % p) == 0;
      case (s.ph)
         0: if (run || (step && !prev_step)) n.ph = 1;
         1: if (tk) n.ph = 2;
         2: if (tk) n.ph = halt ? 7 : 3;
         3: if (tk) n.ph = (io_en && !io_sel) ? 6 : 4;
         4: if (s.age == mw * p - 1) n.ph = 5;
         5: if (tk) begin
               n.ret = (s.ret < cmax) ? s.ret + 1 : s.ret;
               n.ph  = run ? 1 : 0;
            end
         6: if (conf && !prev_conf) n.ph = 4;
         default: ;
      endcase
      n.age = (n.ph != s.ph) ? 0 : s.age + 1;
      return n;
   endfunction

   function automatic logic [9:0] ev(input ms_t s, input int p, input int mw);
      bit tk;
      logic [2:0] ph;
      tk = ((s.age + 1) % p) == 0;
      ph = s.ph[2:0];
      return {ph, s.ph == 1 && tk, s.ph == 3 && tk, s.ph == 4 && s.age == mw * p - 1,
              s.ph == 5 && tk, s.ph == 5 && tk, s.ph == 6, s.ph == 7};
   endfunction

   task automatic drive();
      case (mode)
         0: begin run = 1; step = 0; halt = 0; io_en = 0; io_sel = 1'($urandom); conf = 1'($urandom); end
         1: begin
            run = 0; halt = 0; io_en = 1'($urandom); io_sel = 1'($urandom);
            if ($urandom_range(0, 15) == 0) step = ~step;
            if ($urandom_range(0, 7) == 0) conf = ~conf;
         end
         2: begin
            if ($urandom_range(0, 31) == 0) run = ~run;
            if ($urandom_range(0, 11) == 0) step = ~step;
            if ($urandom_range(0, 5) == 0) conf = ~conf;
            halt = ($urandom_range(0, 63) == 0);
            io_en = 1'($urandom); io_sel = 1'($urandom);
         end
         3: begin
            halt = 1; io_en = 1; io_sel = 0;
            run = 1'($urandom); step = 1'($urandom); conf = 1'($urandom);
         end
         default: begin
            run = m_run; step = m_step; halt = m_halt; io_en = m_io_en; io_sel = m_io_sel; conf = m_conf;
         end
      endcase
   endtask

   task automatic mreset();
      mf = '{0, 0, 0}; msl = '{0, 0, 0};
      prev_step = 0; prev_conf = 0;
   endtask

   task automatic cycle();
      @(negedge clk);
      chk("fast", 32'(f_vec), 32'(ev(mf, P_F, MW_F)));
      chk("fast_ret", 32'(f_ret), mf.ret);
      chk("slow", 32'(s_vec), 32'(ev(msl, P_S, MW_S)));
      chk("slow_ret", 32'(s_ret), msl.ret);
      pc_f += int'(f_pc);
      bad_strb += int'(f_ee) + int'(f_wb) + int'(s_ee) + int'(s_wb);
      drive();
      rst = rst_req[0];
      if (rst) mreset();
      else begin
         mf  = nxt(mf, P_F, MW_F, (1 << CW_F) - 1);
         msl = nxt(msl, P_S, MW_S, (1 << CW_S) - 1);
         prev_step = step; prev_conf = conf;
      end
   endtask

   task automatic do_reset(input int new_mode);
      rst_req = 1; mode = 4;
      m_run = 0; m_step = 0; m_halt = 0; m_io_en = 0; m_io_sel = 0; m_conf = 0;
      repeat (3) cycle();
      mode = new_mode; rst_req = 0;
   endtask

   initial begin
      bit found;
      mreset();
      #1 rst = 1;
      #1;
      chk("rst_fast", 32'(f_vec), 0);
      chk("rst_slow", 32'(s_vec), 0);
      chk("rst_ret", 32'(f_ret) | 32'(s_ret), 0);
      do_reset(0);

      // free run, clean: 6 cycles per instruction on the fast copy, saturates at 15
      repeat (150) cycle();
      chk("sat_ret", 32'(f_ret), 15);

      // directed single-step: three button presses
      do_reset(4);
      pc_f = 0;
      for (int k = 0; k < 3; k++) begin
         m_step = 1; repeat (2) cycle();
         m_step = 0; repeat (18) cycle();
      end
      chk("step_pc", pc_f, 3);
      chk("step_ret", 32'(f_ret), 3);
      chk("step_idle", 32'(f_ph), 0);

      // IO input with Confirm already high on entry
      do_reset(4);
      m_run = 1; m_io_en = 1; m_io_sel = 0; m_conf = 1;
      repeat (30) cycle();
      chk("io_wait_ph", 32'(f_ph), 6);
      chk("io_wait_flag", 32'(f_wt), 1);
      m_conf = 0; repeat (3) cycle();
      chk("io_wait_hold", 32'(f_ph), 6);
      m_conf = 1; repeat (2) cycle();
      chk("io_to_mem", 32'(f_ph), 4);

      // Halt beats IO; nothing commits, and run/step noise keeps it parked
      do_reset(3);
      bad_strb = 0;
      repeat (80) cycle();
      chk("halt_fast", 32'(f_ph), 7);
      chk("halt_slow", 32'(s_ph), 7);
      chk("halt_flag", 32'({f_ht, s_ht}), 3);
      chk("halt_strb", bad_strb, 0);

      // random step mode and mixed traffic
      do_reset(1);
      repeat (400) cycle();
      for (int r = 0; r < 5; r++) begin
         do_reset(2);
         repeat (300) cycle();
      end

      // asynchronous reset in the middle of MEM on the slow copy
      do_reset(0);
      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         cycle();
         if (s_ph == 3'd4 && msl.ph == 4 && msl.ret > 0) found = 1;
      end
      chk("mem_found", 32'(found), 1);
      #2 rst = 1;
      #1;
      chk("arst_slow", 32'(s_vec), 0);
      chk("arst_slow_ret", 32'(s_ret), 0);
      chk("arst_fast", 32'(f_vec), 0);
      mreset();
      rst_req = 1;
      repeat (3) cycle();
      rst_req = 0;
      repeat (40) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
